// File: rtl/neural_acq_pkg.sv
// Shared types for the acquisition sweep path: output packet layout and sweep FSM states.
package neural_acq_pkg;

  localparam int unsigned PKT_TS_MSB   = 63;
  localparam int unsigned PKT_TS_LSB   = 32;
  localparam int unsigned PKT_CH_MSB   = 31;
  localparam int unsigned PKT_CH_LSB   = 28;
  localparam int unsigned PKT_DATA_MSB = 27;
  localparam int unsigned PKT_DATA_LSB = 12;

  typedef struct packed {
    logic [PKT_TS_MSB-PKT_TS_LSB:0]     ts;
    logic [PKT_CH_MSB-PKT_CH_LSB:0]     ch;
    logic [PKT_DATA_MSB-PKT_DATA_LSB:0] data;
    logic [PKT_DATA_LSB-1:0]            rsvd;
  } acq_pkt_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } sweep_state_e;

endpackage

// File: rtl/ch_pending_pick.sv
// Combinational lowest-set-bit encoder over the pending channel vector.
module ch_pending_pick #(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned CH_ID_WIDTH  = 4
) (
  input  logic [NUM_CHANNELS-1:0] pending,
  output logic [CH_ID_WIDTH-1:0]  idx,
  output logic                    any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (pending[i] && !any) begin
        idx = CH_ID_WIDTH'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acq_sweep_scheduler.sv
// Latches a 16-channel snapshot per frame strobe and sweeps enabled channels
// out as 64-bit packets over a valid/ready handshake.
module acq_sweep_scheduler
  import neural_acq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned CH_ID_WIDTH  = 4,
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned TS_WIDTH     = 32
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               frame_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
  input  logic                               csr_enable,
  input  logic [NUM_CHANNELS-1:0]            csr_ch_mask,
  output logic [63:0]                        pkt_data,
  output logic                               pkt_valid,
  input  logic                               pkt_ready,
  output logic                               busy,
  output logic [15:0]                        frame_cnt,
  output logic [15:0]                        overrun_cnt
);

  sweep_state_e          state;
  logic [TS_WIDTH-1:0]   ts_ctr;
  logic [DATA_WIDTH-1:0] snap [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] pick_in;
  logic [NUM_CHANNELS-1:0] pick_onehot;
  logic [CH_ID_WIDTH-1:0]  pick_idx;
  logic                    pick_any;
  acq_pkt_t                pkt;

  // pending excludes the channel currently presented, so one encoder yields
  // the next channel directly and the output stays fully registered.
  assign pick_in     = (state == IDLE) ? csr_ch_mask : pending;
  assign pick_onehot = NUM_CHANNELS'(1) << pick_idx;

  ch_pending_pick #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_ID_WIDTH  (CH_ID_WIDTH)
  ) u_pick (
    .pending (pick_in),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  assign pkt_data = pkt;
  assign busy     = (state == SWEEP);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      ts_ctr      <= '0;
      pending     <= '0;
      pkt         <= '0;
      pkt_valid   <= 1'b0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) snap[i] <= '0;
    end else begin
      ts_ctr <= ts_ctr + 1'b1;
      case (state)
        IDLE: begin
          if (frame_valid && csr_enable) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++)
              snap[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            frame_cnt <= frame_cnt + 1'b1;
            pending   <= csr_ch_mask & ~pick_onehot;
            if (pick_any) begin
              state     <= SWEEP;
              pkt_valid <= 1'b1;
              pkt       <= '{ts: ts_ctr, ch: pick_idx,
                             data: ch_data[pick_idx*DATA_WIDTH +: DATA_WIDTH], rsvd: '0};
            end
          end
        end
        SWEEP: begin
          if (frame_valid && (overrun_cnt != '1))
            overrun_cnt <= overrun_cnt + 1'b1;
          if (pkt_ready) begin
            if (pick_any) begin
              pkt.ch   <= pick_idx;
              pkt.data <= snap[pick_idx];
              pending  <= pending & ~pick_onehot;
            end else begin
              state     <= IDLE;
              pkt_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sweep_scheduler.sv
// Bench for acq_sweep_scheduler: directed scenarios plus random traffic against a queue-based packet model.
module tb_acq_sweep_scheduler;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         frame_valid;
  logic [255:0] ch_data;
  logic         csr_enable;
  logic [15:0]  csr_ch_mask;
  logic [63:0]  pkt_data;
  logic         pkt_valid;
  logic         pkt_ready;
  logic         busy;
  logic [15:0]  frame_cnt;
  logic [15:0]  overrun_cnt;

  acq_sweep_scheduler #(
    .DATA_WIDTH   (16),
    .CH_ID_WIDTH  (4),
    .NUM_CHANNELS (16),
    .TS_WIDTH     (32)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .frame_valid (frame_valid),
    .ch_data     (ch_data),
    .csr_enable  (csr_enable),
    .csr_ch_mask (csr_ch_mask),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun_cnt (overrun_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: the packets still owed by the current frame, in emission order.
  logic [63:0] q [$];
  logic [31:0] m_ts;
  logic [15:0] m_frames;
  logic [15:0] m_over;
  logic [15:0] d [16];
  int unsigned hs;
  logic        prev_stall;
  logic [63:0] prev_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_clear();
    q.delete();
    m_ts       = '0;
    m_frames   = '0;
    m_over     = '0;
    prev_stall = 1'b0;
    prev_data  = '0;
  endtask

  // Called at a falling edge: check outputs, apply inputs, advance the model across the next rising edge.
  task automatic step(input logic fv, input logic rdy);
    check("pkt_valid", pkt_valid, q.size() != 0);
    check("busy", busy, q.size() != 0);
    check("frame_cnt", frame_cnt, m_frames);
    check("overrun_cnt", overrun_cnt, m_over);
    if (q.size() != 0) check("pkt_data", pkt_data, q[0]);
    if (prev_stall) check("hold_stable", pkt_data, prev_data);
    frame_valid = fv;
    pkt_ready   = rdy;
    for (int i = 0; i < 16; i++) ch_data[i*16 +: 16] = d[i];
    prev_stall = pkt_valid && !rdy;
    prev_data  = pkt_data;
    if (q.size() != 0) begin
      if (fv && m_over != 16'hFFFF) m_over++;
      if (rdy) begin
        void'(q.pop_front());
        hs++;
      end
    end else if (fv && csr_enable) begin
      m_frames++;
      for (int ch = 0; ch < 16; ch++)
        if (csr_ch_mask[ch]) q.push_back({m_ts, 4'(ch), d[ch], 12'h000});
    end
    m_ts++;
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst     = 1'b1;
    frame_valid = 1'b0;
    pkt_ready   = 1'b0;
    #1;
    check("rst_valid", pkt_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frames", frame_cnt, 16'd0);
    check("rst_overrun", overrun_cnt, 16'd0);
    check("rst_data", pkt_data, 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int unsigned n, input logic rdy);
    for (int unsigned k = 0; k < n; k++) step(1'b0, rdy);
  endtask

  initial begin
    int unsigned h0;
    csr_enable  = 1'b1;
    csr_ch_mask = 16'hFFFF;
    ch_data     = '0;
    hs          = 0;
    for (int i = 0; i < 16; i++) d[i] = '0;
    model_clear();

    // T1: all channels, ascending data, always ready
    do_reset();
    for (int i = 0; i < 16; i++) d[i] = 16'(i * 256);
    step(1'b1, 1'b1);
    idle(20, 1'b1);
    check("t1_frames", frame_cnt, 16'd1);

    // T2: disabled block ignores the strobe
    do_reset();
    for (int i = 0; i < 16; i++) d[i] = 16'hAAAA;
    csr_enable = 1'b0;
    step(1'b1, 1'b1);
    idle(100, 1'b1);
    check("t2_frames", frame_cnt, 16'd0);
    check("t2_overrun", overrun_cnt, 16'd0);
    csr_enable = 1'b1;

    // T3: sparse mask
    do_reset();
    csr_ch_mask = 16'h8421;
    h0 = hs;
    step(1'b1, 1'b1);
    idle(10, 1'b1);
    check("t3_count", 64'(hs - h0), 64'd4);

    // T4: backpressure, ready one cycle in three
    do_reset();
    csr_ch_mask = 16'hFFFF;
    for (int i = 0; i < 16; i++) d[i] = 16'($urandom);
    step(1'b1, 1'b0);
    for (int k = 0; k < 60; k++) step(1'b0, (k % 3) == 2);
    check("t4_done", busy, 1'b0);

    // T5: overrun 5 cycles after accept
    do_reset();
    step(1'b1, 1'b1);
    idle(4, 1'b1);
    for (int i = 0; i < 16; i++) d[i] = 16'hDEAD;
    step(1'b1, 1'b1);
    idle(20, 1'b1);
    check("t5_frames", frame_cnt, 16'd1);
    check("t5_overrun", overrun_cnt, 16'd1);

    // T7: strobe on the final handshake cycle counts as overrun
    do_reset();
    csr_ch_mask = 16'h0001;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    idle(4, 1'b1);
    check("t7_frames", frame_cnt, 16'd1);
    check("t7_overrun", overrun_cnt, 16'd1);
    csr_ch_mask = 16'hFFFF;

    // T6: reset after packet 7, then a fresh sweep
    do_reset();
    idle(3, 1'b1);
    h0 = hs;
    step(1'b1, 1'b1);
    for (int k = 0; k < 100 && hs < h0 + 7; k++) step(1'b0, 1'b1);
    check("t6_reached", 64'(hs - h0), 64'd7);
    do_reset();
    idle(5, 1'b1);
    step(1'b1, 1'b1);
    check("t6_first_ch", 64'(pkt_data[31:28]), 64'd0);
    check("t6_fresh_ts", pkt_data[63:32], 64'd5);
    idle(20, 1'b1);

    // Random traffic; enable and mask wander every cycle, including mid-sweep
    do_reset();
    for (int k = 0; k < 800; k++) begin
      logic fv;
      fv = ($urandom_range(0, 9) == 0);
      if (fv) for (int i = 0; i < 16; i++) d[i] = 16'($urandom);
      csr_enable  = ($urandom_range(0, 3) != 0);
      csr_ch_mask = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      step(fv, $urandom_range(0, 3) != 0);
    end
    idle(40, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
